// File: rtl/prng_hpc3_feed_pkg.sv
// Shared constants for the HPC3 randomness feeder: LFSR geometry, taps, seed framing,
// FSM encodings and the gadget randomness-width helper.
package prng_hpc3_feed_pkg;

    localparam int DEFAULTSHARES = 2;

    localparam int STATE_W    = 128;
    localparam int SEED_W     = 32;
    localparam int SEED_BEATS = 4;
    localparam int BEAT_W     = 2;
    localparam int USE_W      = 16;

    localparam int TAP_A = 127;
    localparam int TAP_B = 125;
    localparam int TAP_C = 100;
    localparam int TAP_D = 98;

    localparam logic [1:0] ST_SEED = 2'd0;
    localparam logic [1:0] ST_WARM = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_EXH  = 2'd3;

    // Fresh random bits consumed per evaluation of a d-share HPC3 AND gadget.
    function automatic int hpc3rnd(input int shares);
        return shares * (shares - 1);
    endfunction

endpackage

// File: rtl/prng_lfsr128_step.sv
// Purely combinational N-step unroll of the 128-bit Fibonacci LFSR.
module prng_lfsr128_step
    import prng_hpc3_feed_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [STATE_W-1:0] s_in,
    output logic [STATE_W-1:0] s_out
);

    logic [STATE_W-1:0] acc;

    always_comb begin
        acc = s_in;
        for (int i = 0; i < N; i++) begin
            acc = {acc[STATE_W-2:0], acc[TAP_A] ^ acc[TAP_B] ^ acc[TAP_C] ^ acc[TAP_D]};
        end
        s_out = acc;
    end

endmodule

// File: rtl/prng_hpc3_feed.sv
// Seeded LFSR that hands out RW fresh bits per handshake to a masked HPC3 gadget,
// with warm-up discard, per-seed usage limit and explicit reseed control.
//
// state   | meaning
// --------+-------------------------------------------------------------
// SEED    | collecting 4 seed words, no randomness offered
// WARM    | advancing WARMUP times to discard early output
// RUN     | offering rnd; advance on each accepted transfer
// EXH     | usage limit reached; waiting for reseed
module prng_hpc3_feed
    import prng_hpc3_feed_pkg::*;
#(
    parameter int d       = DEFAULTSHARES,
    parameter int WARMUP  = 16,
    parameter int MAX_USE = 65535,
    localparam int RW     = hpc3rnd(d)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   seed_in,
    input  logic          seed_valid,
    input  logic          reseed,
    output logic [RW-1:0] rnd,
    output logic          rnd_valid,
    input  logic          rnd_ready,
    output logic          reseed_req
);

    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

    logic               rst_sync;
    logic [1:0]         state, state_nxt;
    logic [STATE_W-1:0] s, s_nxt, s_adv, assembled;
    logic [BEAT_W-1:0]  beat, beat_nxt;
    logic [USE_W-1:0]   use_cnt, use_nxt, use_inc;
    logic [WW-1:0]      warm_cnt, warm_nxt;
    logic [RW-1:0]      rnd_q, rnd_nxt;
    logic               rnd_valid_q, reseed_req_q;
    logic               xfer;

    prng_lfsr128_step #(.N(RW)) u_step (
        .s_in  (s),
        .s_out (s_adv)
    );

    // Single-flop release synchroniser: logic starts updating on the second edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 1'b0;
        else        rst_sync <= 1'b1;
    end

    assign xfer      = rnd_valid_q & rnd_ready;
    assign assembled = {seed_in, s[STATE_W-1:SEED_W]};
    assign use_inc   = (use_cnt == '1) ? use_cnt : use_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        beat_nxt  = beat;
        use_nxt   = use_cnt;
        warm_nxt  = warm_cnt;

        case (state)
            ST_SEED: begin
                if (seed_valid) begin
                    s_nxt = assembled;
                    if (beat == BEAT_W'(SEED_BEATS - 1)) begin
                        if (assembled == '0) s_nxt = STATE_W'(1);
                        beat_nxt  = '0;
                        warm_nxt  = WW'(WARMUP);
                        state_nxt = (WARMUP > 0) ? ST_WARM : ST_RUN;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
            end
            ST_WARM: begin
                s_nxt    = s_adv;
                warm_nxt = warm_cnt - 1'b1;
                if (warm_cnt == WW'(1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (xfer) begin
                    s_nxt   = s_adv;
                    use_nxt = use_inc;
                    if (use_inc == USE_W'(MAX_USE)) state_nxt = ST_EXH;
                end
            end
            default: ;
        endcase

        // A transfer in the reseed cycle still consumes its value; a seed beat does not land.
        if (reseed) begin
            state_nxt = ST_SEED;
            beat_nxt  = '0;
            use_nxt   = '0;
            if (state == ST_SEED) s_nxt = s;
        end

        rnd_nxt = (state_nxt == ST_RUN) ? s_nxt[RW-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_SEED;
            s            <= '0;
            beat         <= '0;
            use_cnt      <= '0;
            warm_cnt     <= '0;
            rnd_q        <= '0;
            rnd_valid_q  <= 1'b0;
            reseed_req_q <= 1'b0;
        end else if (rst_sync) begin
            state        <= state_nxt;
            s            <= s_nxt;
            beat         <= beat_nxt;
            use_cnt      <= use_nxt;
            warm_cnt     <= warm_nxt;
            rnd_q        <= rnd_nxt;
            rnd_valid_q  <= (state_nxt == ST_RUN);
            reseed_req_q <= (state_nxt == ST_EXH);
        end
    end

    assign rnd        = rnd_q;
    assign rnd_valid  = rnd_valid_q;
    assign reseed_req = reseed_req_q;

endmodule

// File: tb/tb_prng_hpc3_feed.sv
// Directed bench: dut0 (no warm-up, 3 uses per seed) and dut1 (3 warm-up cycles) share stimulus.
module tb_prng_hpc3_feed;

    logic        clk;
    logic        rst_n;
    logic [31:0] seed_in;
    logic        seed_valid;
    logic        reseed;
    logic        rnd_ready;
    logic [1:0]  rnd0, rnd1;
    logic        rnd_valid0, rnd_valid1;
    logic        reseed_req0, reseed_req1;

    int total;
    int bad;

    prng_hpc3_feed #(.d(2), .WARMUP(0), .MAX_USE(3)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_in    (seed_in),
        .seed_valid (seed_valid),
        .reseed     (reseed),
        .rnd        (rnd0),
        .rnd_valid  (rnd_valid0),
        .rnd_ready  (rnd_ready),
        .reseed_req (reseed_req0)
    );

    prng_hpc3_feed #(.d(2), .WARMUP(3), .MAX_USE(65535)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_in    (seed_in),
        .seed_valid (seed_valid),
        .reseed     (reseed),
        .rnd        (rnd1),
        .rnd_valid  (rnd_valid1),
        .rnd_ready  (rnd_ready),
        .reseed_req (reseed_req1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reseed();
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
    endtask

    task automatic send_seed(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        seed_valid = 1'b1;
        seed_in = w0; tick();
        seed_in = w1; tick();
        seed_in = w2; tick();
        seed_in = w3; tick();
        seed_valid = 1'b0;
        seed_in = '0;
    endtask

    task automatic handshake();
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (rnd_valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rnd_valid0); end
        total++; if (rnd0 !== 2'b00) begin bad++; $display("FAIL reset_rnd: got %b want 00", rnd0); end
        total++; if (reseed_req0 !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", reseed_req0); end
        total++; if (rnd_valid1 !== 1'b0) begin bad++; $display("FAIL reset_valid1: got %b want 0", rnd_valid1); end
        // release between edges; the beat on the first edge must be ignored
        rst_n = 1'b1;
        seed_valid = 1'b1;
        seed_in = 32'h2;
        tick();
        total++; if (rnd_valid0 !== 1'b0) begin bad++; $display("FAIL release_edge1: got %b want 0", rnd_valid0); end
        seed_in = 32'h1; tick();
        seed_in = 32'h0; tick();
        tick();
        total++; if (rnd_valid0 !== 1'b0) begin bad++; $display("FAIL release_3beats: got %b want 0", rnd_valid0); end
        tick();
        seed_valid = 1'b0;
        total++; if (rnd_valid0 !== 1'b1) begin bad++; $display("FAIL release_run_valid: got %b want 1", rnd_valid0); end
        total++; if (rnd0 !== 2'b01) begin bad++; $display("FAIL release_run_rnd: got %b want 01", rnd0); end
        handshake();
        total++; if (rnd0 !== 2'b00) begin bad++; $display("FAIL first_xfer_rnd: got %b want 00", rnd0); end
        total++; if (rnd_valid0 !== 1'b1) begin bad++; $display("FAIL first_xfer_valid: got %b want 1", rnd_valid0); end
    endtask

    task automatic test_zero_seed();
        pulse_reseed();
        total++; if (rnd_valid0 !== 1'b0) begin bad++; $display("FAIL zero_reseed_valid: got %b want 0", rnd_valid0); end
        total++; if (rnd0 !== 2'b00) begin bad++; $display("FAIL zero_reseed_rnd: got %b want 00", rnd0); end
        send_seed(32'h0, 32'h0, 32'h0, 32'h0);
        total++; if (rnd_valid0 !== 1'b1) begin bad++; $display("FAIL zero_valid: got %b want 1", rnd_valid0); end
        total++; if (rnd0 !== 2'b01) begin bad++; $display("FAIL zero_rnd: got %b want 01", rnd0); end
        handshake();
        total++; if (rnd0 !== 2'b00) begin bad++; $display("FAIL zero_xfer_rnd: got %b want 00", rnd0); end
    endtask

    task automatic test_taps();
        pulse_reseed();
        send_seed(32'h0, 32'h0, 32'h0, 32'h4);
        total++; if (rnd0 !== 2'b00) begin bad++; $display("FAIL tap98_init: got %b want 00", rnd0); end
        handshake();
        total++; if (rnd0 !== 2'b10) begin bad++; $display("FAIL tap98_adv1: got %b want 10", rnd0); end
        handshake();
        total++; if (rnd0 !== 2'b10) begin bad++; $display("FAIL tap100_adv2: got %b want 10", rnd0); end
    endtask

    task automatic test_stall();
        pulse_reseed();
        send_seed(32'h5, 32'h0, 32'h0, 32'h2000_0000);
        total++; if (rnd0 !== 2'b01) begin bad++; $display("FAIL stall_init: got %b want 01", rnd0); end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (rnd0 !== 2'b01 || rnd_valid0 !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold cycle %0d: got rnd=%b valid=%b want rnd=01 valid=1", i, rnd0, rnd_valid0);
            end
        end
        handshake();
        total++; if (rnd0 !== 2'b10) begin bad++; $display("FAIL stall_release: got %b want 10", rnd0); end
    endtask

    task automatic test_back_to_back_exhaust();
        int n;
        pulse_reseed();
        send_seed(32'h1, 32'h0, 32'h0, 32'h0);
        n = 0;
        rnd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (rnd_valid0) n++;
            tick();
        end
        rnd_ready = 1'b0;
        total++; if (n !== 3) begin bad++; $display("FAIL exh_transfers: got %0d want 3", n); end
        total++; if (reseed_req0 !== 1'b1) begin bad++; $display("FAIL exh_req: got %b want 1", reseed_req0); end
        total++; if (rnd_valid0 !== 1'b0) begin bad++; $display("FAIL exh_valid: got %b want 0", rnd_valid0); end
        total++; if (rnd0 !== 2'b00) begin bad++; $display("FAIL exh_rnd: got %b want 00", rnd0); end
        send_seed(32'h1, 32'h0, 32'h0, 32'h0);
        total++; if (reseed_req0 !== 1'b1) begin bad++; $display("FAIL exh_seed_ignored_req: got %b want 1", reseed_req0); end
        total++; if (rnd_valid0 !== 1'b0) begin bad++; $display("FAIL exh_seed_ignored_valid: got %b want 0", rnd_valid0); end
        pulse_reseed();
        total++; if (reseed_req0 !== 1'b0) begin bad++; $display("FAIL exh_reseed_req: got %b want 0", reseed_req0); end
        send_seed(32'h1, 32'h0, 32'h0, 32'h0);
        total++; if (rnd_valid0 !== 1'b1 || rnd0 !== 2'b01) begin
            bad++; $display("FAIL exh_reseeded: got valid=%b rnd=%b want valid=1 rnd=01", rnd_valid0, rnd0);
        end
    endtask

    task automatic test_reseed_mid_seed();
        pulse_reseed();
        seed_valid = 1'b1;
        seed_in = 32'h3; tick();
        tick();
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        seed_in = 32'h1; tick();
        seed_in = 32'h0; tick();
        tick();
        total++; if (rnd_valid0 !== 1'b0) begin bad++; $display("FAIL midseed_3beats: got %b want 0", rnd_valid0); end
        tick();
        seed_valid = 1'b0;
        total++; if (rnd_valid0 !== 1'b1) begin bad++; $display("FAIL midseed_valid: got %b want 1", rnd_valid0); end
        total++; if (rnd0 !== 2'b01) begin bad++; $display("FAIL midseed_rnd: got %b want 01", rnd0); end
    endtask

    task automatic test_warmup();
        pulse_reseed();
        send_seed(32'h0, 32'h0, 32'h0, 32'h0400_0000);
        total++; if (rnd_valid0 !== 1'b1 || rnd0 !== 2'b00) begin
            bad++; $display("FAIL warm_nowarm_dut: got valid=%b rnd=%b want valid=1 rnd=00", rnd_valid0, rnd0);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rnd_valid1 !== 1'b0 || rnd1 !== 2'b00) begin
                bad++; $display("FAIL warm_hidden cycle %0d: got valid=%b rnd=%b want valid=0 rnd=00", i, rnd_valid1, rnd1);
            end
            tick();
        end
        total++; if (rnd_valid1 !== 1'b1) begin bad++; $display("FAIL warm_done_valid: got %b want 1", rnd_valid1); end
        total++; if (rnd1 !== 2'b01) begin bad++; $display("FAIL warm_done_rnd: got %b want 01", rnd1); end
        handshake();
        total++; if (rnd1 !== 2'b00) begin bad++; $display("FAIL warm_xfer_rnd: got %b want 00", rnd1); end
    endtask

    task automatic test_async_reset();
        pulse_reseed();
        send_seed(32'h1, 32'h0, 32'h0, 32'h0);
        total++; if (rnd_valid0 !== 1'b1) begin bad++; $display("FAIL areset_pre_valid: got %b want 1", rnd_valid0); end
        rnd_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rnd_valid0 !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b want 0", rnd_valid0); end
        total++; if (rnd0 !== 2'b00) begin bad++; $display("FAIL areset_rnd: got %b want 00", rnd0); end
        rnd_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_seed(32'h1, 32'h0, 32'h0, 32'h0);
        total++; if (rnd_valid0 !== 1'b1 || rnd0 !== 2'b01) begin
            bad++; $display("FAIL areset_reseed: got valid=%b rnd=%b want valid=1 rnd=01", rnd_valid0, rnd0);
        end
        total++; if (reseed_req0 !== 1'b0) begin bad++; $display("FAIL areset_req: got %b want 0", reseed_req0); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        seed_in = '0;
        seed_valid = 1'b0;
        reseed = 1'b0;
        rnd_ready = 1'b0;
        test_reset();
        test_zero_seed();
        test_taps();
        test_stall();
        test_back_to_back_exhaust();
        test_reseed_mid_seed();
        test_warmup();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prng_hpc3_feed.md
PRNG_HPC3_FEED -- requirements
Module: prng_hpc3_feed

Interface
REQ-001 Parameter d, default `DEFAULTSHARES (2), number of shares of the fed gadget.
REQ-002 Parameter WARMUP, default 16, cycles of discarded output after each seed load.
REQ-003 Parameter MAX_USE, default 65535, transfers allowed per seed before reseed is mandatory.
REQ-004 Derived RW = hpc3rnd = d*(d-1), randomness bits per transfer; legal range 2..64.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 seed_in  in  32  seed word, word 0 = state bits [31:0].
REQ-008 seed_valid  in  1  seed word present; accepted only in SEED state.
REQ-009 reseed  in  1  one-cycle request to abandon current seed and enter SEED.
REQ-010 rnd  out  RW  fresh randomness for a masked gadget's rnd port.
REQ-011 rnd_valid  out  1  rnd holds an unused value.
REQ-012 rnd_ready  in  1  consumer takes rnd this cycle.
REQ-013 reseed_req  out  1  MAX_USE exhausted; new seed required.

Function
REQ-014 State s is 128 bits; one LFSR step: b = s[127]^s[125]^s[100]^s[98]; s <= {s[126:0], b}.
REQ-015 One advance = RW consecutive steps, computed combinationally in one cycle.
REQ-016 rnd = s[RW-1:0] of the current state; rnd is 0 whenever rnd_valid is 0.
REQ-017 FSM states: SEED, WARM, RUN, EXH.
REQ-018 SEED: each seed_valid beat shifts seed_in into s, word by word; after 4 beats go to WARM (WARMUP>0) or RUN.
REQ-019 If the 4 assembled words are all zero, s is set to 128'h1 on entry to WARM/RUN.
REQ-020 WARM: advance every cycle for WARMUP cycles, rnd_valid=0, then go to RUN.
REQ-021 RUN: rnd_valid=1; on rnd_valid&rnd_ready advance s and increment use counter in the same cycle.
REQ-022 RUN without rnd_ready: s and rnd stay unchanged; each value is offered once and never reissued after a transfer.
REQ-023 When the transfer that makes the use count equal MAX_USE completes, go to EXH; rnd_valid=0 next cycle.
REQ-024 EXH: reseed_req=1, rnd_valid=0; seed_valid ignored until reseed, which goes to SEED.
REQ-025 reseed in any state: next state SEED, beat count and use counter cleared, rnd_valid=0 next cycle; a handshake in that same cycle still completes and is counted.
REQ-026 reseed and seed_valid in the same cycle in SEED: reseed wins, beat discarded, beat count restarts at 0.
REQ-027 Use counter is 16 bits, saturating; never wraps.

Reset
REQ-028 rst_n low: state SEED, s=0, beat count 0, use counter 0, rnd_valid=0, rnd=0, reseed_req=0, independent of clk.
REQ-029 Release of rst_n is synchronised to clk; first seed beat is accepted on the second rising edge after release.
REQ-030 Reset mid-transfer discards the pending value; no value is offered again after reset.

Structure
REQ-031 RW is computed from the hpc3rnd constant in the shared header MSKand_hpc3.vh; no local redefinition.
REQ-032 Taps, state width (128), and seed-beat count (4) are constants in the shared header.
REQ-033 Combinational unrolled stepper is a sub-module prng_lfsr128_step with parameter N (steps) and no clock.
REQ-034 rnd is driven directly from registers; no combinational path from rnd_ready to rnd.

Verification
REQ-035 d=2, WARMUP=0, seed beats 1,0,0,0 -> RUN, rnd=2'b01 valid; after one handshake rnd=2'b00 (s=4).
REQ-036 Seed 0,0,0,0 -> s forced to 1; same sequence as REQ-035.
REQ-037 rnd_ready held low 10 cycles in RUN -> rnd constant and rnd_valid=1 throughout; s advances only on ready.
REQ-038 MAX_USE=3, ready held high -> exactly 3 transfers, then reseed_req=1, rnd_valid=0; seed_valid ignored until reseed.
REQ-039 reseed pulse after 2 of 4 seed beats -> 4 new beats required; the earlier words are overwritten.
REQ-040 rst_n low mid-RUN, asynchronously between edges -> rnd_valid=0 and rnd=0 before the next edge; SEED after release.
